voice_allocator: RTL and testbench

Polyphonic voice scheduler between the MIDI parser and the tone-generator bank. It accepts note-on/note-off events through a valid/ready handshake and assigns each note to one of `VOICES` generator slots. When all slots are busy it steals the oldest one. It drives per-voice gate, note, velocity and a retrigger pulse that the oscillator/envelope datapath consumes.

---
 rtl/voice_allocator.sv | 150 +++++++++++++++
 tb/tb_voice_allocator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice scheduler with match/free/oldest-steal selection.
// One voice is examined per SCAN cycle; all voice state changes happen only in COMMIT or on ALL_OFF.
module voice_allocator #(
  parameter int VOICES = 4
) (
  input  logic                  CLK_50MHZ,
  input  logic                  RST_N,
  input  logic                  EVT_VALID,
  output logic                  EVT_READY,
  input  logic                  EVT_ON,
  input  logic [6:0]            EVT_NOTE,
  input  logic [6:0]            EVT_VEL,
  input  logic                  ALL_OFF,
  output logic [VOICES-1:0]     VOICE_GATE,
  output logic [7*VOICES-1:0]   VOICE_NOTE,
  output logic [7*VOICES-1:0]   VOICE_VEL,
  output logic [VOICES-1:0]     VOICE_TRIG
);
  localparam int IW = $clog2(VOICES);
  localparam logic [IW-1:0] LAST = IW'(VOICES - 1);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d, sel;
  logic match_ok_q, match_ok_d, free_ok_q, free_ok_d, old_ok_q, old_ok_d;
  logic ev_on_q, ev_on_d, ready_q, ready_d;
  logic [6:0] ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
  logic [VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
  logic [VOICES-1:0][6:0] note_q, note_d, vel_q, vel_d;
  logic [VOICES-1:0][7:0] age_q, age_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    match_idx_d = match_idx_q;
    free_idx_d = free_idx_q;
    old_idx_d = old_idx_q;
    match_ok_d = match_ok_q;
    free_ok_d = free_ok_q;
    old_ok_d = old_ok_q;
    ev_on_d = ev_on_q;
    ev_note_d = ev_note_q;
    ev_vel_d = ev_vel_q;
    ready_d = 1'b0;
    gate_d = gate_q;
    note_d = note_q;
    vel_d = vel_q;
    age_d = age_q;
    trig_d = '0;
    sel = match_ok_q ? match_idx_q : free_ok_q ? free_idx_q : old_idx_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (EVT_VALID && ready_q) begin
          state_d = SCAN;
          ready_d = 1'b0;
          idx_d = '0;
          match_ok_d = 1'b0;
          free_ok_d = 1'b0;
          old_ok_d = 1'b0;
          ev_on_d = EVT_ON && (EVT_VEL != 7'd0);
          ev_note_d = EVT_NOTE;
          ev_vel_d = EVT_VEL;
        end
      end
      SCAN: begin
        if (gate_q[idx_q] && note_q[idx_q] == ev_note_q && !match_ok_q) begin
          match_ok_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!gate_q[idx_q] && !free_ok_q) begin
          free_ok_d = 1'b1;
          free_idx_d = idx_q;
        end
        // Strict greater-than keeps the lowest index on equal ages.
        if (gate_q[idx_q] && (!old_ok_q || age_q[idx_q] > age_q[old_idx_q])) begin
          old_ok_d = 1'b1;
          old_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == LAST) ? COMMIT : SCAN;
      end
      COMMIT: begin
        state_d = IDLE;
        ready_d = 1'b1;
        for (int v = 0; v < VOICES; v++)
          if (ev_on_q && IW'(v) == sel) begin
            gate_d[v] = 1'b1;
            note_d[v] = ev_note_q;
            vel_d[v] = ev_vel_q;
            age_d[v] = 8'd0;
            trig_d[v] = 1'b1;
          end else if (ev_on_q && gate_q[v]) begin
            age_d[v] = age_q[v] + {7'd0, age_q[v] != 8'hff};
          end
        if (!ev_on_q && match_ok_q) gate_d[match_idx_q] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (ALL_OFF) begin
      state_d = IDLE;
      ready_d = 1'b1;
      gate_d = '0;
      age_d = '0;
      trig_d = '0;
    end
  end
  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q <= '0;
      match_idx_q <= '0;
      free_idx_q <= '0;
      old_idx_q <= '0;
      match_ok_q <= 1'b0;
      free_ok_q <= 1'b0;
      old_ok_q <= 1'b0;
      ev_on_q <= 1'b0;
      ev_note_q <= '0;
      ev_vel_q <= '0;
      ready_q <= 1'b0;
      gate_q <= '0;
      note_q <= '0;
      vel_q <= '0;
      age_q <= '0;
      trig_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      match_idx_q <= match_idx_d;
      free_idx_q <= free_idx_d;
      old_idx_q <= old_idx_d;
      match_ok_q <= match_ok_d;
      free_ok_q <= free_ok_d;
      old_ok_q <= old_ok_d;
      ev_on_q <= ev_on_d;
      ev_note_q <= ev_note_d;
      ev_vel_q <= ev_vel_d;
      ready_q <= ready_d;
      gate_q <= gate_d;
      note_q <= note_d;
      vel_q <= vel_d;
      age_q <= age_d;
      trig_q <= trig_d;
    end
  end
  assign EVT_READY = ready_q;
  assign VOICE_GATE = gate_q;
  assign VOICE_NOTE = note_q;
  assign VOICE_VEL = vel_q;
  assign VOICE_TRIG = trig_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scenarios plus randomized events against a behavioural voice model.
module tb_voice_allocator;
  localparam int V = 4;
  logic clk = 1'b0, rst_n = 1'b0, evt_valid = 1'b0, evt_on = 1'b0, all_off = 1'b0;
  logic [6:0] evt_note = '0, evt_vel = '0;
  logic evt_ready;
  logic [V-1:0] gate, trig;
  logic [7*V-1:0] vnote, vvel;
  int checks = 0, errors = 0;
  bit m_gate[V];
  int m_note[V], m_vel[V], m_age[V], m_trig;
  voice_allocator #(.VOICES(V)) dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .EVT_VALID(evt_valid), .EVT_READY(evt_ready),
    .EVT_ON(evt_on), .EVT_NOTE(evt_note), .EVT_VEL(evt_vel), .ALL_OFF(all_off),
    .VOICE_GATE(gate), .VOICE_NOTE(vnote), .VOICE_VEL(vvel), .VOICE_TRIG(trig)
  );
  always #10 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear(input bit full);
    for (int v = 0; v < V; v++) begin
      m_gate[v] = 0;
      m_age[v] = 0;
      if (full) begin m_note[v] = 0; m_vel[v] = 0; end
    end
    m_trig = 0;
  endtask
  task automatic model_apply(input bit on, input int n, input int vl);
    int mt = -1, fr = -1, od = -1, sel;
    m_trig = 0;
    for (int v = 0; v < V; v++) begin
      if (m_gate[v] && m_note[v] == n && mt < 0) mt = v;
      if (!m_gate[v] && fr < 0) fr = v;
      if (m_gate[v] && (od < 0 || m_age[v] > m_age[od])) od = v;
    end
    if (on && vl != 0) begin
      sel = (mt >= 0) ? mt : (fr >= 0) ? fr : od;
      for (int v = 0; v < V; v++)
        if (v != sel && m_gate[v]) m_age[v] = (m_age[v] < 255) ? m_age[v] + 1 : 255;
      m_gate[sel] = 1;
      m_note[sel] = n;
      m_vel[sel] = vl;
      m_age[sel] = 0;
      m_trig = 1 << sel;
    end else if (mt >= 0) m_gate[mt] = 0;
  endtask
  function automatic logic [V-1:0] exp_gate();
    logic [V-1:0] r;
    for (int v = 0; v < V; v++) r[v] = m_gate[v];
    return r;
  endfunction
  function automatic logic [7*V-1:0] exp_note();
    logic [7*V-1:0] r;
    for (int v = 0; v < V; v++) r[7*v +: 7] = 7'(m_note[v]);
    return r;
  endfunction
  function automatic logic [7*V-1:0] exp_vel();
    logic [7*V-1:0] r;
    for (int v = 0; v < V; v++) r[7*v +: 7] = 7'(m_vel[v]);
    return r;
  endfunction
  // Drives one event and returns just after the commit edge; lo counts busy samples with
  // EVT_READY low, quiet says outputs held still and no trig appeared while busy.
  task automatic send_evt(input bit on, input int n, input int vl, output int lo, output bit quiet);
    int w = 0;
    logic [V-1:0] g0;
    logic [7*V-1:0] n0, v0;
    while (!evt_ready && w < 20) begin tick(); w++; end
    checks++;
    if (evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait: ready=%b required 1", evt_ready);
    end
    evt_valid = 1'b1; evt_on = on; evt_note = 7'(n); evt_vel = 7'(vl);
    g0 = gate; n0 = vnote; v0 = vvel;
    tick();
    evt_valid = 1'b0; evt_on = 1'($urandom); evt_note = 7'($urandom); evt_vel = 7'($urandom);
    lo = 0; quiet = 1;
    for (int i = 0; i <= V; i++) begin
      if (evt_ready === 1'b0) lo++;
      if (trig !== '0 || gate !== g0 || vnote !== n0 || vvel !== v0) quiet = 0;
      if (i < V) tick();
    end
    tick();
    model_apply(on, n, vl);
  endtask
  task automatic pulse_all_off();
    all_off = 1'b1;
    tick();
    all_off = 1'b0;
    model_clear(0);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    model_clear(1);
    checks++;
    if (evt_ready !== 1'b0 || gate !== '0 || trig !== '0 || vnote !== '0 || vvel !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b gate=%b trig=%b note=%h vel=%h required all 0", evt_ready, gate, trig, vnote, vvel);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", evt_ready); end
  endtask
  task automatic test_first_note();
    int lo; bit q;
    send_evt(1, 60, 100, lo, q);
    checks++;
    if (lo != 5 || !q || evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_latency: ready_low=%0d quiet=%0d ready=%b required 5 1 1", lo, q, evt_ready);
    end
    checks++;
    if (gate !== 4'b0001 || vnote[6:0] !== 7'd60 || vvel[6:0] !== 7'd100 || trig !== 4'b0001) begin
      errors++;
      $display("FAIL first_assign: gate=%b note=%0d vel=%0d trig=%b required 0001 60 100 0001", gate, vnote[6:0], vvel[6:0], trig);
    end
    tick();
    checks++;
    if (trig !== 4'b0000) begin errors++; $display("FAIL first_trig_width: trig=%b required 0000", trig); end
  endtask
  task automatic test_steal();
    int lo; bit q;
    pulse_all_off();
    send_evt(1, 60, 90, lo, q);
    send_evt(1, 62, 90, lo, q);
    send_evt(1, 64, 90, lo, q);
    send_evt(1, 65, 90, lo, q);
    checks++;
    if (gate !== 4'b1111 || vnote !== exp_note()) begin
      errors++;
      $display("FAIL steal_full: gate=%b note=%h required 1111 %h", gate, vnote, exp_note());
    end
    send_evt(1, 67, 90, lo, q);
    checks++;
    if (trig !== 4'b0001 || gate !== 4'b1111 || vnote !== {7'd65, 7'd64, 7'd62, 7'd67} || vvel !== exp_vel()) begin
      errors++;
      $display("FAIL steal_oldest: trig=%b gate=%b note=%h required 0001 1111 %h", trig, gate, vnote, {7'd65, 7'd64, 7'd62, 7'd67});
    end
  endtask
  task automatic test_retrigger();
    int lo, tp = 0; bit q;
    pulse_all_off();
    send_evt(1, 60, 50, lo, q);
    if (trig === 4'b0001) tp++;
    send_evt(1, 60, 110, lo, q);
    if (trig === 4'b0001) tp++;
    checks++;
    if (tp != 2 || gate !== 4'b0001 || vvel[6:0] !== 7'd110 || vnote !== exp_note()) begin
      errors++;
      $display("FAIL retrigger: trig_pulses=%0d gate=%b vel0=%0d required 2 0001 110", tp, gate, vvel[6:0]);
    end
  endtask
  task automatic test_note_off();
    int lo; bit q;
    pulse_all_off();
    send_evt(1, 60, 80, lo, q);
    send_evt(1, 62, 80, lo, q);
    send_evt(0, 62, 0, lo, q);
    checks++;
    if (gate !== 4'b0001 || vnote[13:7] !== 7'd62 || trig !== '0) begin
      errors++;
      $display("FAIL note_off_match: gate=%b note1=%0d trig=%b required 0001 62 0000", gate, vnote[13:7], trig);
    end
    send_evt(1, 64, 0, lo, q);
    checks++;
    if (gate !== exp_gate() || vnote !== exp_note() || trig !== '0 || !q) begin
      errors++;
      $display("FAIL vel0_is_off: gate=%b note=%h trig=%b required %b %h 0000", gate, vnote, trig, exp_gate(), exp_note());
    end
    send_evt(0, 70, 0, lo, q);
    checks++;
    if (gate !== exp_gate() || vnote !== exp_note() || vvel !== exp_vel() || trig !== '0) begin
      errors++;
      $display("FAIL note_off_nomatch: gate=%b note=%h trig=%b required %b %h 0000", gate, vnote, trig, exp_gate(), exp_note());
    end
  endtask
  task automatic test_all_off_scan();
    bit bad = 0;
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd72; evt_vel = 7'd99;
    tick();
    evt_valid = 1'b0;
    repeat (2) tick();
    pulse_all_off();
    checks++;
    if (gate !== 4'b0000 || trig !== '0 || evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL all_off_scan: gate=%b trig=%b ready=%b required 0000 0000 1", gate, trig, evt_ready);
    end
    repeat (V + 2) begin
      tick();
      if (trig !== '0 || gate !== '0 || vnote !== exp_note()) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL all_off_discard: gate=%b note=%h required 0000 %h", gate, vnote, exp_note()); end
  endtask
  task automatic test_reset_commit();
    int lo; bit q;
    pulse_all_off();
    send_evt(1, 10, 11, lo, q);
    send_evt(1, 20, 21, lo, q);
    checks++;
    if (gate !== 4'b0011) begin errors++; $display("FAIL pre_reset_gates: gate=%b required 0011", gate); end
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd30; evt_vel = 7'd31;
    tick();
    evt_valid = 1'b0;
    repeat (V) tick();
    rst_n = 1'b0;
    tick();
    model_clear(1);
    checks++;
    if (gate !== '0 || trig !== '0 || vnote !== '0 || vvel !== '0 || evt_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_commit: gate=%b trig=%b note=%h vel=%h ready=%b required all 0", gate, trig, vnote, vvel, evt_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL reset_commit_ready: got %b required 1", evt_ready); end
    send_evt(1, 40, 41, lo, q);
    checks++;
    if (gate !== 4'b0001 || vnote[6:0] !== 7'd40 || trig !== 4'b0001) begin
      errors++;
      $display("FAIL after_reset_note: gate=%b note0=%0d trig=%b required 0001 40 0001", gate, vnote[6:0], trig);
    end
  endtask
  task automatic test_random();
    int lo, n, vl; bit q, on;
    pulse_all_off();
    for (int i = 0; i < 60; i++) begin
      on = ($urandom_range(0, 3) != 0);
      n = $urandom_range(60, 67);
      vl = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
      send_evt(on, n, vl, lo, q);
      checks++;
      if (lo != 5 || !q || evt_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_timing[%0d]: ready_low=%0d quiet=%0d ready=%b required 5 1 1", i, lo, q, evt_ready);
      end
      checks++;
      if (gate !== exp_gate() || vnote !== exp_note() || vvel !== exp_vel() || trig !== V'(m_trig)) begin
        errors++;
        $display("FAIL rand_state[%0d]: gate=%b note=%h vel=%h trig=%b required %b %h %h %b",
                 i, gate, vnote, vvel, trig, exp_gate(), exp_note(), exp_vel(), V'(m_trig));
      end
    end
  endtask
  initial begin
    test_reset();
    test_first_note();
    test_steal();
    test_retrigger();
    test_note_off();
    test_all_off_scan();
    test_reset_commit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
